// File: rtl/regfile_sb_if.sv
// Bundled request/response signals of the scoreboarded register file.
// The master drives writes, reads, issue and flush; the slave returns read data and busy flags.
interface regfile_sb_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int NWR  = 2
);
   localparam int AW = $clog2(NREG);

   logic                 rdy;
   logic [NWR-1:0]       we;
   logic [NWR*AW-1:0]    waddr;
   logic [NWR*XLEN-1:0]  wdata;
   logic [NRD-1:0]       re;
   logic [NRD*AW-1:0]    raddr;
   logic [NRD*XLEN-1:0]  rdata;
   logic [NRD-1:0]       rbusy;
   logic                 iss_valid;
   logic [AW-1:0]        iss_addr;
   logic                 flush;

   modport master (
      output rdy, we, waddr, wdata, re, raddr, iss_valid, iss_addr, flush,
      input  rdata, rbusy
   );

   modport slave (
      input  rdy, we, waddr, wdata, re, raddr, iss_valid, iss_addr, flush,
      output rdata, rbusy
   );
endinterface

// File: rtl/regfile_sb.sv
// Multi-ported register file with per-register pending (scoreboard) bits.
// Reads are combinational and forward same-cycle write data. x0 is hardwired to zero.
module regfile_sb #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int NWR  = 2
) (
   input logic          clk,
   input logic          rst,
   regfile_sb_if.slave  bus
);
   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0]     r_regs [NREG];
   logic [NREG-1:0]     r_pend;
   logic [NREG-1:0]     w_pend_nxt;
   logic [NRD*XLEN-1:0] w_rdata;
   logic [NRD-1:0]      w_rbusy;

   // Write ports clear pending; issue sets it after that, so issue wins; flush overrides both.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      w_pend_nxt = r_pend;
      for (int i = 0; i < NWR; i++) begin
         if (bus.we[i] && (bus.waddr[i*AW +: AW] != '0))
            w_pend_nxt[bus.waddr[i*AW +: AW]] = 1'b0;
      end
      if (bus.flush)
         w_pend_nxt = '0;
      else if (bus.iss_valid && (bus.iss_addr != '0))
         w_pend_nxt[bus.iss_addr] = 1'b1;
      w_pend_nxt[0] = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so later ports win by update order, not race.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the array is reset explicitly because software relies on all registers reading zero.
         for (int j = 0; j < NREG; j++)
            r_regs[j] <= '0;
      end else if (bus.rdy) begin
         for (int i = 0; i < NWR; i++) begin
            if (bus.we[i] && (bus.waddr[i*AW +: AW] != '0))
               r_regs[bus.waddr[i*AW +: AW]] <= bus.wdata[i*XLEN +: XLEN];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_pend <= '0;
      else if (bus.rdy)
         r_pend <= w_pend_nxt;
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   w_ra;
      logic [XLEN-1:0] w_d;
      logic            w_b;

      assign w_ra = bus.raddr[k*AW +: AW];

      // Highest-index matching write port forwards last, so it takes precedence.
      always_comb begin
         w_d = '0;
         w_b = 1'b0;
         if (!rst && bus.re[k] && (w_ra != '0)) begin
            w_d = r_regs[w_ra];
            w_b = r_pend[w_ra];
            for (int i = 0; i < NWR; i++) begin
               if (bus.we[i] && (bus.waddr[i*AW +: AW] == w_ra)) begin
                  w_d = bus.wdata[i*XLEN +: XLEN];
                  w_b = bus.iss_valid && (bus.iss_addr == w_ra);
               end
            end
         end
      end

      assign w_rdata[k*XLEN +: XLEN] = w_d;
      assign w_rbusy[k]              = w_b;
   end

   assign bus.rdata = w_rdata;
   assign bus.rbusy = w_rbusy;
endmodule
